// File: rtl/nonce_scheduler.sv
// Nonce scheduler: issues a job's nonce range to the SHA-256d hasher, filters returned hashes
// against a leading-zero target and reports hits as a held golden_nonce plus a toggle flag.
// Defining NONCE_SCHED_STATS_EN adds a saturating per-job count of current-epoch results.
module nonce_scheduler #(
  parameter int ZERO_BITS     = 32,
  parameter int MAX_INFLIGHT  = 64,
  parameter int GN_FIFO_DEPTH = 4,
  parameter int GN_HOLD       = 64
) (
  input  logic         hash_clk,
  input  logic         rst_n,
  input  logic         new_work,
  input  logic [255:0] midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  nonce_min,
  input  logic [31:0]  nonce_max,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [255:0] req_midstate,
  output logic [127:0] req_data,
  output logic         req_epoch,
  input  logic         res_valid,
  input  logic [31:0]  res_nonce,
  input  logic         res_epoch,
  input  logic [255:0] res_hash,
  output logic [31:0]  golden_nonce,
  output logic         new_golden_nonce,
  output logic         busy,
  output logic         gn_overflow,
  output logic [31:0]  hashes_done
);

  localparam int IF_W  = $clog2(MAX_INFLIGHT) + 1;
  localparam int AW    = (GN_FIFO_DEPTH > 1) ? $clog2(GN_FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(GN_FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(GN_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              epoch_q;
  logic [255:0]      midstate_q;
  logic [95:0]       work_data_q;
  logic [31:0]       nonce_q, nonce_d;
  logic [31:0]       nonce_max_q;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic              req_valid_q;
  logic              busy_q;
  logic              handshake;

  assign handshake = req_valid_q & req_ready;

  // Results of any epoch retire an outstanding request, so a new job never clears the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    inflight_d = inflight_q;
    case ({handshake, res_valid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    nonce_d = nonce_q;
    if (new_work) begin
      state_d = (nonce_min > nonce_max) ? S_DONE : S_RUN;
      nonce_d = nonce_min;
    end else begin
      case (state_q)
        S_RUN: begin
          if (handshake) begin
            // Compare before incrementing so nonce_max = FFFFFFFF never wraps to 0.
            if (nonce_q == nonce_max_q) state_d = S_DRAIN;
            else                        nonce_d = nonce_q + 32'd1;
          end
        end
        S_DRAIN: if (inflight_d == '0) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      epoch_q     <= 1'b0;
      midstate_q  <= '0;
      work_data_q <= '0;
      nonce_q     <= '0;
      nonce_max_q <= '0;
      inflight_q  <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      inflight_q  <= inflight_d;
      req_valid_q <= (state_d == S_RUN) && (inflight_d < IF_W'(MAX_INFLIGHT));
      busy_q      <= (state_d == S_RUN) || (state_d == S_DRAIN);
      if (new_work) begin
        epoch_q     <= ~epoch_q;
        midstate_q  <= midstate;
        work_data_q <= work_data;
        nonce_max_q <= nonce_max;
      end
    end
  end

  assign req_valid    = req_valid_q;
  assign req_midstate = midstate_q;
  assign req_data     = {work_data_q, nonce_q};
  assign req_epoch    = epoch_q;
  assign busy         = busy_q;

  logic            hit_now;
  logic            hit_valid_q;
  logic [31:0]     hit_nonce_q;
  logic [31:0]     fifo_mem [GN_FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic [31:0]     gn_q;
  logic            new_gn_q;
  logic [TMR_W-1:0] timer_q;
  logic            fifo_full, pop, do_write, drop;
  logic            unused_hash_bits;

  assign unused_hash_bits = ^res_hash[255-ZERO_BITS:0];
  assign hit_now   = res_valid && (res_epoch == epoch_q) && (res_hash[255 -: ZERO_BITS] == '0);
  assign fifo_full = (count_q == CW'(GN_FIFO_DEPTH));
  assign pop       = (timer_q == '0) && (count_q != '0) && !new_work;
  assign do_write  = hit_valid_q && (!fifo_full || pop) && !new_work;
  assign drop      = hit_valid_q && fifo_full && !pop && !new_work;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(GN_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: queue storage carries no reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge hash_clk) begin
    if (do_write) fifo_mem[wr_ptr_q] <= hit_nonce_q;
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid_q <= 1'b0;
      hit_nonce_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      gn_q        <= '0;
      new_gn_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      hit_valid_q <= hit_now && !new_work;
      hit_nonce_q <= res_nonce;
      if (new_work) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (do_write) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({do_write, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (drop) overflow_q <= 1'b1;
      end
      // The reporting side ignores new_work so a pending report always completes its hold.
      if (pop) begin
        gn_q     <= fifo_mem[rd_ptr_q];
        new_gn_q <= ~new_gn_q;
        timer_q  <= TMR_W'(GN_HOLD - 1);
      end else if (timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

  assign golden_nonce     = gn_q;
  assign new_golden_nonce = new_gn_q;
  assign gn_overflow      = overflow_q;

`ifdef NONCE_SCHED_STATS_EN
  logic [31:0] hashes_q;

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n)                                            hashes_q <= '0;
    else if (new_work)                                     hashes_q <= '0;
    else if (res_valid && (res_epoch == epoch_q) && (hashes_q != '1)) hashes_q <= hashes_q + 32'd1;
  end

  assign hashes_done = hashes_q;
`else
  assign hashes_done = 32'd0;
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler: a fixed-latency hasher model returns results, expected
// requests and golden nonces are queued from job ranges, and monitors compare on DUT activity.
`timescale 1ns/1ps
module tb_nonce_scheduler;
  localparam int ZERO_BITS     = 32;
  localparam int MAX_INFLIGHT  = 64;
  localparam int GN_FIFO_DEPTH = 4;
  localparam int GN_HOLD       = 64;

  logic         hash_clk = 1'b0;
  logic         rst_n;
  logic         new_work;
  logic [255:0] midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_min, nonce_max;
  logic         req_valid, req_ready;
  logic [255:0] req_midstate;
  logic [127:0] req_data;
  logic         req_epoch;
  logic         res_valid;
  logic [31:0]  res_nonce;
  logic         res_epoch;
  logic [255:0] res_hash;
  logic [31:0]  golden_nonce;
  logic         new_golden_nonce, busy, gn_overflow;
  logic [31:0]  hashes_done;

  nonce_scheduler #(
    .ZERO_BITS(ZERO_BITS), .MAX_INFLIGHT(MAX_INFLIGHT),
    .GN_FIFO_DEPTH(GN_FIFO_DEPTH), .GN_HOLD(GN_HOLD)
  ) dut (
    .hash_clk(hash_clk), .rst_n(rst_n), .new_work(new_work), .midstate(midstate),
    .work_data(work_data), .nonce_min(nonce_min), .nonce_max(nonce_max),
    .req_valid(req_valid), .req_ready(req_ready), .req_midstate(req_midstate),
    .req_data(req_data), .req_epoch(req_epoch), .res_valid(res_valid), .res_nonce(res_nonce),
    .res_epoch(res_epoch), .res_hash(res_hash), .golden_nonce(golden_nonce),
    .new_golden_nonce(new_golden_nonce), .busy(busy), .gn_overflow(gn_overflow),
    .hashes_done(hashes_done)
  );

  always #5 hash_clk = ~hash_clk;

  typedef struct {
    logic [31:0]  nonce;
    logic         epoch;
    logic [255:0] mid;
    logic [95:0]  wd;
  } req_t;

  typedef struct {
    logic [31:0] nonce;
    logic        epoch;
    int unsigned due;
  } pend_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  req_t        exp_req[$];
  logic [31:0] exp_gn[$];
  pend_t       pend[$];

  // Knobs written only by the main process.
  int unsigned lat        = 8;
  int unsigned ready_pct  = 100;
  int unsigned stall_from = '1;
  logic        hit_en     = 1'b0;
  logic [31:0] hit_lo     = '0;
  logic [31:0] hit_hi     = '0;
  logic        tb_epoch   = 1'b0;
  int          burst_base = 0;
  int          res_base   = 0;

  // Written only by the hasher model.
  int          outstanding  = 0;
  int          hs_count     = 0;
  int          stall_cycles = 0;
  int          res_match    = 0;
  int unsigned last_hs_cyc  = 0;

  // Written only by the golden-nonce monitor.
  int          toggles = 0;

  always @(posedge hash_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] make_hash(input logic [31:0] n);
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
    if (hit_en && n >= hit_lo && n <= hit_hi) begin
      h[255:224] = 32'h0;
      h[223]     = 1'b1;
    end else if ($urandom_range(1) == 0) begin
      h[255:224] = 32'h1;
    end else begin
      h[255:224] = $urandom | 32'h8000_0000;
    end
    return h;
  endfunction

  function automatic logic [31:0] exp_hashes();
`ifdef NONCE_SCHED_STATS_EN
    return 32'(res_match - res_base);
`else
    return 32'd0;
`endif
  endfunction

  // Hasher model: drives ready/results and checks every accepted request against the scoreboard.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data  = '0;
  always @(negedge hash_clk) begin
    if (!rst_n) begin
      pend.delete();
      res_valid   = 1'b0;
      res_nonce   = '0;
      res_epoch   = 1'b0;
      res_hash    = '0;
      req_ready   = 1'b0;
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      pend_t p;
      res_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        res_valid = 1'b1;
        res_nonce = p.nonce;
        res_epoch = p.epoch;
        res_hash  = make_hash(p.nonce);
        outstanding--;
        if (p.epoch == tb_epoch) res_match++;
      end
      if (cyc >= stall_from && cyc - stall_from < 5) req_ready = 1'b0;
      else req_ready = ($urandom_range(99) < ready_pct);
      if (prev_stall) begin
        check("req_valid_held", {255'd0, req_valid}, 256'd1);
        check("req_data_held", {128'd0, req_data}, {128'd0, prev_data});
      end
      prev_stall = req_valid && !req_ready;
      prev_data  = req_data;
      if (prev_stall) stall_cycles++;
      if (req_valid && req_ready) begin
        req_t e;
        check("req_expected", {255'd0, exp_req.size() != 0}, 256'd1);
        if (exp_req.size() != 0) begin
          e = exp_req.pop_front();
          check("req_nonce", {224'd0, req_data[31:0]}, {224'd0, e.nonce});
          check("req_epoch", {255'd0, req_epoch}, {255'd0, e.epoch});
          check("req_work_data", {160'd0, req_data[127:32]}, {160'd0, e.wd});
          check("req_midstate", req_midstate, e.mid);
        end
        pend.push_back('{nonce: req_data[31:0], epoch: req_epoch, due: cyc + lat});
        outstanding++;
        hs_count++;
        last_hs_cyc = cyc + 1;
      end
    end
  end

  // Golden-nonce monitor: each toggle pops the expected nonce; between toggles the value must hold.
  logic        gn_prev = 1'b0;
  logic [31:0] gn_last = '0;
  int unsigned last_tog = 0;
  always @(negedge hash_clk) begin
    if (!rst_n) begin
      gn_prev = 1'b0;
      gn_last = '0;
    end else if (new_golden_nonce !== gn_prev) begin
      gn_prev = new_golden_nonce;
      check("gn_expected", {255'd0, exp_gn.size() != 0}, 256'd1);
      if (exp_gn.size() != 0) check("golden_nonce", {224'd0, golden_nonce}, {224'd0, exp_gn.pop_front()});
      if (toggles > burst_base) check("gn_spacing", {224'd0, cyc - last_tog}, 256'(GN_HOLD));
      toggles++;
      last_tog = cyc;
      gn_last  = golden_nonce;
    end else begin
      check("golden_nonce_held", {224'd0, golden_nonce}, {224'd0, gn_last});
    end
  end

  task automatic start_job(input logic [31:0] lo, input logic [31:0] hi);
    @(negedge hash_clk);
    #1;
    for (int i = 0; i < 8; i++) midstate[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) work_data[i*32 +: 32] = $urandom;
    nonce_min = lo;
    nonce_max = hi;
    new_work  = 1'b1;
    tb_epoch  = ~tb_epoch;
    res_base  = res_match;
    exp_req.delete();
    for (longint n = longint'(lo); n <= longint'(hi); n++)
      exp_req.push_back('{nonce: 32'(n), epoch: tb_epoch, mid: midstate, wd: work_data});
    @(negedge hash_clk);
    #1;
    new_work = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge hash_clk);
      n++;
    end
    check("reached_idle", {255'd0, busy}, 256'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge hash_clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_valid"}, {255'd0, req_valid}, 256'd0);
    check({tag, "_req_midstate"}, req_midstate, 256'd0);
    check({tag, "_req_data"}, {128'd0, req_data}, 256'd0);
    check({tag, "_req_epoch"}, {255'd0, req_epoch}, 256'd0);
    check({tag, "_golden_nonce"}, {224'd0, golden_nonce}, 256'd0);
    check({tag, "_new_golden_nonce"}, {255'd0, new_golden_nonce}, 256'd0);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
    check({tag, "_gn_overflow"}, {255'd0, gn_overflow}, 256'd0);
    check({tag, "_hashes_done"}, {224'd0, hashes_done}, 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0, tg0, st0, mx, n;
    logic [31:0] lo, hi, len;
    rst_n = 1'b0; new_work = 1'b0; midstate = '0; work_data = '0;
    nonce_min = '0; nonce_max = '0;
    repeat (3) @(negedge hash_clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    wait_cycles(3);
    check_zero_outputs("post_reset");

    // Four nonces, latency 8: first request one cycle after new_work, DONE 8 cycles after last issue.
    start_job(32'h10, 32'h13);
    check("first_req_valid", {255'd0, req_valid}, 256'd1);
    check("busy_in_run", {255'd0, busy}, 256'd1);
    hs0 = hs_count;
    wait_idle(200);
    check("done_latency", {224'd0, cyc}, {224'd0, last_hs_cyc + 8});
    check("four_requests_left", 256'(exp_req.size()), 256'd0);
    check("hashes_done_small", {224'd0, hashes_done}, {224'd0, exp_hashes()});

    // Top of the nonce space: two requests and no wrap to zero.
    hs0 = hs_count;
    start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_idle(200);
    wait_cycles(20);
    check("wrap_req_count", 256'(hs_count - hs0), 256'd2);
    check("wrap_idle_valid", {255'd0, req_valid}, 256'd0);

    // Empty range goes straight to DONE.
    hs0 = hs_count;
    start_job(32'd5, 32'd4);
    check("empty_busy", {255'd0, busy}, 256'd0);
    check("empty_req_valid", {255'd0, req_valid}, 256'd0);
    wait_cycles(20);
    check("empty_req_count", 256'(hs_count - hs0), 256'd0);

    // Three back-to-back hits report at exact GN_HOLD spacing.
    hit_en = 1'b1; hit_lo = 32'h20; hit_hi = 32'h22;
    for (int i = 0; i < 3; i++) exp_gn.push_back(32'h20 + 32'(i));
    burst_base = toggles; tg0 = toggles;
    start_job(32'h20, 32'h22);
    wait_idle(200);
    wait_cycles(3 * GN_HOLD + 20);
    check("three_hit_toggles", 256'(toggles - tg0), 256'd3);
    check("three_hit_no_overflow", {255'd0, gn_overflow}, 256'd0);

    // Six hits into a depth-4 queue: one dropped, overflow flagged.
    hit_lo = 32'h40; hit_hi = 32'h45;
    for (int i = 0; i < 5; i++) exp_gn.push_back(32'h40 + 32'(i));
    burst_base = toggles; tg0 = toggles;
    start_job(32'h40, 32'h45);
    wait_idle(200);
    wait_cycles(6 * GN_HOLD + 20);
    check("six_hit_toggles", 256'(toggles - tg0), 256'd5);
    check("six_hit_overflow", {255'd0, gn_overflow}, 256'd1);

    // A five-cycle stall mid-job: request held, no nonce skipped; new_work clears the overflow.
    hit_en = 1'b0;
    st0 = stall_cycles;
    start_job(32'h80, 32'h8F);
    check("overflow_cleared", {255'd0, gn_overflow}, 256'd0);
    wait_cycles(3);
    stall_from = cyc + 1;
    wait_idle(200);
    check("stall_seen", {255'd0, (stall_cycles - st0) >= 5}, 256'd1);
    check("stall_requests_left", 256'(exp_req.size()), 256'd0);
    stall_from = '1;

    // Long hasher latency: outstanding requests cap at MAX_INFLIGHT.
    lat = 100; mx = 0; n = 0;
    start_job(32'h1000, 32'h104F);
    while (busy && n < 2000) begin
      @(negedge hash_clk);
      #1;
      if (outstanding > mx) mx = outstanding;
      n++;
    end
    check("inflight_idle", {255'd0, busy}, 256'd0);
    check("inflight_cap", 256'(mx), 256'(MAX_INFLIGHT));
    check("hashes_done_cap", {224'd0, hashes_done}, {224'd0, exp_hashes()});
    lat = 8;

    // new_work with ~10 requests outstanding: old-epoch hits ignored, drain waits for them.
    lat = 16; hit_en = 1'b1; hit_lo = 32'h100; hit_hi = 32'h1FF;
    tg0 = toggles;
    start_job(32'h100, 32'h1FF);
    n = 0;
    while (outstanding < 10 && n < 100) begin
      @(negedge hash_clk);
      #1;
      n++;
    end
    check("ten_inflight_reached", {255'd0, outstanding >= 10}, 256'd1);
    start_job(32'h300, 32'h305);
    wait_idle(300);
    wait_cycles(GN_HOLD);
    check("old_epoch_no_toggle", 256'(toggles - tg0), 256'd0);
    check("rejob_requests_left", 256'(exp_req.size()), 256'd0);
    check("rejob_drained", 256'(outstanding), 256'd0);
    check("hashes_done_rejob", {224'd0, hashes_done}, {224'd0, exp_hashes()});
    lat = 8;

    // Random jobs with one hit each and a random ready pattern.
    ready_pct = 70;
    for (int j = 0; j < 8; j++) begin
      lo  = $urandom & 32'h7FFF_FFFF;
      len = 32'($urandom_range(20, 1));
      hi  = lo + len - 1;
      hit_lo = lo + 32'($urandom_range(int'(len) - 1));
      hit_hi = hit_lo;
      exp_gn.push_back(hit_lo);
      burst_base = toggles + 1;
      tg0 = toggles;
      start_job(lo, hi);
      wait_idle(500);
      wait_cycles(GN_HOLD + 10);
      check("rand_toggle", 256'(toggles - tg0), 256'd1);
      check("rand_requests_left", 256'(exp_req.size()), 256'd0);
      check("rand_hashes_done", {224'd0, hashes_done}, {224'd0, exp_hashes()});
    end
    ready_pct = 100; hit_en = 1'b0;

    // Reset mid-RUN: outputs return to zero at once, next job carries epoch 1.
    lat = 16;
    start_job(32'h500, 32'h5FF);
    wait_cycles(20);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    exp_req.delete();
    exp_gn.delete();
    tb_epoch = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    lat = 8;
    start_job(32'h600, 32'h603);
    wait_idle(200);
    check("post_reset_requests_left", 256'(exp_req.size()), 256'd0);
    check("post_reset_hashes", {224'd0, hashes_done}, {224'd0, exp_hashes()});

    wait_cycles(5);
    check("final_exp_req_empty", 256'(exp_req.size()), 256'd0);
    check("final_exp_gn_empty", 256'(exp_gn.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
